solution_uart_tx: RTL and testbench

SOLUTION_UART_TX -- requirements
Module: solution_uart_tx

---
 rtl/rc4_pkg.sv | 31 +++
 rtl/uart_tx_serializer.sv | 79 +++++++
 rtl/solution_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_solution_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the solution UART reporter: transmit FSM states,
// ASCII codes used in the report text, and a nibble-to-hex-character helper.
package rc4_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StHdr,
      StKey,
      StReq,
      StRead,
      StWaitQ,
      StSend,
      StTrailer,
      StFin
   } tx_state_e;

   localparam logic [7:0] AsciiK     = 8'h4B;
   localparam logic [7:0] AsciiEq    = 8'h3D;
   localparam logic [7:0] AsciiColon = 8'h3A;
   localparam logic [7:0] AsciiN     = 8'h4E;
   localparam logic [7:0] AsciiO     = 8'h4F;
   localparam logic [7:0] AsciiE     = 8'h45;
   localparam logic [7:0] AsciiCr    = 8'h0D;
   localparam logic [7:0] AsciiLf    = 8'h0A;

   // Uppercase hex digit: '0'..'9' then 'A'..'F' ('A' = 0x37 + 10).
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART bit timer and shift register with a load/ready handshake.
// Defining SOLUTION_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_tx_serializer #(
   parameter int unsigned clk_div = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       tx_o
);

`ifdef SOLUTION_TX_PARITY_EN
   localparam int unsigned FrameBits = 11;
`else
   localparam int unsigned FrameBits = 10;
`endif
   localparam int unsigned DivW = (clk_div > 1) ? $clog2(clk_div) : 1;
   localparam int unsigned CntW = 4;

   logic [FrameBits-1:0] frame_q, frame_d, frame_load;
   logic [DivW-1:0]      div_q, div_d;
   logic [CntW-1:0]      bit_q, bit_d;
   logic                 active_q, active_d;
   logic                 bit_end, last_bit;

`ifdef SOLUTION_TX_PARITY_EN
   assign frame_load = {1'b1, ^data_i, data_i, 1'b0};
`else
   assign frame_load = {1'b1, data_i, 1'b0};
`endif

   assign bit_end  = (div_q == DivW'(clk_div - 1));
   assign last_bit = active_q && bit_end && (bit_q == CntW'(FrameBits - 1));
   // Ready in the final stop-bit cycle so the next frame follows with no idle bit.
   assign ready_o  = !active_q || last_bit;
   assign tx_o     = active_q ? frame_q[0] : 1'b1;

   always_comb begin
      frame_d  = frame_q;
      div_d    = div_q;
      bit_d    = bit_q;
      active_d = active_q;
      if (load_i && ready_o) begin
         frame_d  = frame_load;
         div_d    = '0;
         bit_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (bit_end) begin
            div_d = '0;
            if (last_bit) begin
               active_d = 1'b0;
            end else begin
               frame_d = {1'b1, frame_q[FrameBits-1:1]};
               bit_d   = bit_q + 1'b1;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_q  <= '1;
         div_q    <= '0;
         bit_q    <= '0;
         active_q <= 1'b0;
      end else begin
         frame_q  <= frame_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/solution_uart_tx.sv
// Reports a key search result over UART: "K=<hex key>:<RAM bytes>\r\n" or "NONE\r\n".
// SOLUTION_TX_PARITY_EN (in the serializer) selects 11-bit even-parity frames.
module solution_uart_tx
   import rc4_pkg::*;
#(
   parameter int unsigned addr_width        = 5,
   parameter int unsigned data_width        = 8,
   parameter int unsigned secret_key_length = 24,
   parameter int unsigned clk_div           = 434
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         no_solution,
   input  logic [secret_key_length-1:0] secret_key,
   output logic [addr_width-1:0]        sol_ram_addr,
   input  logic [data_width-1:0]        sol_ram_q,
   output logic                         sol_ram_access_request,
   input  logic                         sol_ram_access_granted,
   output logic                         tx,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned KeyNibbles = secret_key_length / 4;

   tx_state_e             state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [data_width-1:0] byte_q, byte_d;
   logic                  nosol_q, nosol_d;
   logic                  ser_load, ser_ready;
   logic [7:0]            ser_data, hdr_last;
   logic [3:0]            key_nib;

   always_comb begin
      key_nib = 4'h0;
      for (int i = 0; i < KeyNibbles; i++) begin
         if (idx_q == 8'(i)) key_nib = secret_key[secret_key_length-1-4*i -: 4];
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      byte_d   = byte_q;
      nosol_d  = nosol_q;
      ser_load = 1'b0;
      ser_data = 8'hFF;
      hdr_last = nosol_q ? 8'd3 : 8'd1;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StHdr;
               idx_d   = '0;
               addr_d  = '0;
               nosol_d = no_solution;
            end
         end
         StHdr: begin
            if (nosol_q) begin
               case (idx_q[1:0])
                  2'd1:    ser_data = AsciiO;
                  2'd3:    ser_data = AsciiE;
                  default: ser_data = AsciiN;
               endcase
            end else begin
               ser_data = (idx_q == 8'd0) ? AsciiK : AsciiEq;
            end
            if (ser_ready) begin
               ser_load = 1'b1;
               if (idx_q == hdr_last) begin
                  idx_d   = '0;
                  state_d = nosol_q ? StTrailer : StKey;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         StKey: begin
            ser_data = (idx_q == 8'(KeyNibbles)) ? AsciiColon : hex_char(key_nib);
            if (ser_ready) begin
               ser_load = 1'b1;
               if (idx_q == 8'(KeyNibbles)) begin
                  idx_d   = '0;
                  state_d = StReq;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         StReq: begin
            if (sol_ram_access_granted) state_d = StRead;
         end
         StRead:  state_d = StWaitQ;
         StWaitQ: begin
            // Two cycles after the address change: synchronous RAM data is valid.
            byte_d  = sol_ram_q;
            state_d = StSend;
         end
         StSend: begin
            ser_data = byte_q;
            if (ser_ready) begin
               ser_load = 1'b1;
               addr_d   = addr_q + 1'b1;
               state_d  = (addr_d == '0) ? StTrailer : StRead;
            end
         end
         StTrailer: begin
            ser_data = (idx_q == 8'd0) ? AsciiCr : AsciiLf;
            if (idx_q == 8'd2) begin
               // LF is in flight; ready rises in its final stop-bit cycle.
               if (ser_ready) begin
                  idx_d   = '0;
                  state_d = StFin;
               end
            end else if (ser_ready) begin
               ser_load = 1'b1;
               idx_d    = idx_q + 8'd1;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         addr_q  <= '0;
         byte_q  <= '0;
         nosol_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
         nosol_q <= nosol_d;
      end
   end

   assign sol_ram_access_request = (state_q == StReq) || (state_q == StRead) ||
                                   (state_q == StWaitQ) || (state_q == StSend);
   assign sol_ram_addr = (sol_ram_access_request && sol_ram_access_granted) ? addr_q : '0;
   assign busy         = (state_q != StIdle) && (state_q != StFin);
   assign done         = (state_q == StFin);

   uart_tx_serializer #(
      .clk_div (clk_div)
   ) u_serializer (
      .clk_i   (clk),
      .rst_ni  (reset),
      .load_i  (ser_load),
      .data_i  (ser_data),
      .ready_o (ser_ready),
      .tx_o    (tx)
   );

endmodule

// File: tb/tb_solution_uart_tx.sv
// Scoreboard bench for solution_uart_tx: a UART decoder pops expected bytes per frame.
module tb_solution_uart_tx;

   localparam int ClkDiv = 4;
`ifdef SOLUTION_TX_PARITY_EN
   localparam int FrameCycles = 11 * ClkDiv;
`else
   localparam int FrameCycles = 10 * ClkDiv;
`endif
   localparam int Budget = 5000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        no_solution;
   logic [23:0] secret_key;
   logic [4:0]  sol_ram_addr;
   logic [7:0]  sol_ram_q;
   logic        sol_ram_access_request;
   logic        gnt;
   logic        tx, busy, done;

   logic [7:0]  mem [32];
   logic [7:0]  sb [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          req_cnt = 0;
   int          addr_bad = 0;
   int          rx_cnt = 0;
   int          rst_epoch = 0;

   always #5 clk = ~clk;

   always @(posedge clk) sol_ram_q <= mem[sol_ram_addr];

   solution_uart_tx #(
      .addr_width        (5),
      .data_width        (8),
      .secret_key_length (24),
      .clk_div           (ClkDiv)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .no_solution            (no_solution),
      .secret_key             (secret_key),
      .sol_ram_addr           (sol_ram_addr),
      .sol_ram_q              (sol_ram_q),
      .sol_ram_access_request (sol_ram_access_request),
      .sol_ram_access_granted (gnt),
      .tx                     (tx),
      .busy                   (busy),
      .done                   (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_msg(input bit ns);
      string hx;
      string s;
      logic [23:0] k;
      hx = "0123456789ABCDEF";
      if (ns) begin
         s = "NONE";
         for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
      end else begin
         sb.push_back(8'h4B);
         sb.push_back(8'h3D);
         k = secret_key;
         for (int i = 0; i < 6; i++) begin
            sb.push_back(hx[int'(k[23:20])]);
            k = k << 4;
         end
         sb.push_back(8'h3A);
         for (int i = 0; i < 32; i++) sb.push_back(mem[i]);
      end
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
   endtask

   task automatic pulse_start(input bit ns);
      @(negedge clk);
      start = 1'b1;
      no_solution = ns;
      @(negedge clk);
      start = 1'b0;
      no_solution = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int base;
      int n;
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < Budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == base) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_rx(input int target);
      int n;
      n = 0;
      while (rx_cnt < target && n < Budget) begin
         @(negedge clk);
         n++;
      end
      if (rx_cnt < target) check_eq("rx_timeout", rx_cnt, target);
   endtask

   task automatic wait_tx_low();
      int n;
      n = 0;
      while (tx !== 1'b0 && n < Budget) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) check_eq("tx_low_timeout", 32'(tx), 32'd0);
   endtask

   initial begin
      int base_done, base_req, base_rx, tx_high_bad, n;
      reset = 1'b0;
      start = 1'b0;
      no_solution = 1'b0;
      secret_key = 24'h1A2B3C;
      gnt = 1'b1;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);

      fork
         // Per-cycle observers.
         forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
               done_cnt++;
               check_eq("busy_at_done", 32'(busy), 32'd0);
            end
            if (sol_ram_access_request) req_cnt++;
            if (!gnt && sol_ram_addr != 5'd0) addr_bad++;
         end
         // UART decoder: samples mid-bit, discards frames cut by reset.
         begin
            int ep, t0, last_t0, pos;
            logic [7:0] b;
            logic b0, p, s;
            last_t0 = -100000;
            pos = 0;
            forever begin
               @(negedge clk);
               if (reset && tx === 1'b0) begin
                  ep = rst_epoch;
                  t0 = cyc;
                  repeat (ClkDiv / 2) @(negedge clk);
                  b0 = tx;
                  for (int i = 0; i < 8; i++) begin
                     repeat (ClkDiv) @(negedge clk);
                     b[i] = tx;
                  end
                  p = 1'b0;
`ifdef SOLUTION_TX_PARITY_EN
                  repeat (ClkDiv) @(negedge clk);
                  p = tx;
`endif
                  repeat (ClkDiv) @(negedge clk);
                  s = tx;
                  if (ep == rst_epoch && reset) begin
                     pos = (t0 - last_t0 > 3 * FrameCycles) ? 0 : pos + 1;
                     if (pos >= 1 && pos <= 5) check_eq("frame_gap", t0 - last_t0, FrameCycles);
                     last_t0 = t0;
                     check_eq("start_bit", 32'(b0), 32'd0);
                     check_eq("stop_bit", 32'(s), 32'd1);
`ifdef SOLUTION_TX_PARITY_EN
                     check_eq("parity_bit", 32'(p), 32'(^b));
`else
                     p = 1'b0;
`endif
                     if (sb.size() == 0) check_eq("unexpected_byte", 32'(b), 32'hFFFF);
                     else check_eq("rx_byte", 32'(b), 32'(sb.pop_front()));
                     rx_cnt++;
                  end
               end
            end
         end
         // Stimulus.
         begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("rst_tx", 32'(tx), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            check_eq("rst_req", 32'(sol_ram_access_request), 32'd0);
            check_eq("rst_addr", 32'(sol_ram_addr), 32'd0);
            @(negedge clk);
            reset = 1'b1;
            repeat (3) @(negedge clk);

            // Normal key report.
            base_done = done_cnt;
            push_msg(1'b0);
            pulse_start(1'b0);
            check_eq("busy_after_start", 32'(busy), 32'd1);
            wait_done("normal");
            check_eq("normal_left", sb.size(), 0);
            check_eq("normal_dones", done_cnt - base_done, 1);
            check_eq("normal_busy_end", 32'(busy), 32'd0);

            // No solution: no RAM request at all.
            base_done = done_cnt;
            base_req = req_cnt;
            push_msg(1'b1);
            pulse_start(1'b1);
            wait_done("nosol");
            check_eq("nosol_left", sb.size(), 0);
            check_eq("nosol_req", req_cnt - base_req, 0);
            check_eq("nosol_dones", done_cnt - base_done, 1);

            // Grant withheld for 100 cycles after the header.
            gnt = 1'b0;
            base_done = done_cnt;
            base_rx = rx_cnt;
            addr_bad = 0;
            push_msg(1'b0);
            pulse_start(1'b0);
            wait_rx(base_rx + 9);
            check_eq("gnt_req_high", 32'(sol_ram_access_request), 32'd1);
            tx_high_bad = 0;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (tx !== 1'b1) tx_high_bad++;
            end
            check_eq("gnt_tx_idle", tx_high_bad, 0);
            check_eq("gnt_no_ram_byte", rx_cnt - base_rx, 9);
            check_eq("gnt_addr_zero", addr_bad, 0);
            gnt = 1'b1;
            wait_done("gnt");
            check_eq("gnt_left", sb.size(), 0);
            check_eq("gnt_dones", done_cnt - base_done, 1);

            // Start re-pulsed during the third byte must be ignored.
            base_done = done_cnt;
            base_rx = rx_cnt;
            push_msg(1'b0);
            pulse_start(1'b0);
            wait_rx(base_rx + 2);
            wait_tx_low();
            pulse_start(1'b1);
            wait_done("restart");
            repeat (20) @(negedge clk);
            check_eq("restart_left", sb.size(), 0);
            check_eq("restart_dones", done_cnt - base_done, 1);

            // Reset during the 10th byte, then a clean rerun.
            base_done = done_cnt;
            base_rx = rx_cnt;
            push_msg(1'b0);
            pulse_start(1'b0);
            wait_rx(base_rx + 9);
            wait_tx_low();
            repeat (8) @(negedge clk);
            rst_epoch++;
            reset = 1'b0;
            #1;
            check_eq("abort_tx", 32'(tx), 32'd1);
            check_eq("abort_busy", 32'(busy), 32'd0);
            check_eq("abort_req", 32'(sol_ram_access_request), 32'd0);
            sb.delete();
            repeat (60) @(negedge clk);
            check_eq("abort_no_done", done_cnt - base_done, 0);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            push_msg(1'b0);
            pulse_start(1'b0);
            wait_done("rerun");
            check_eq("rerun_left", sb.size(), 0);
            check_eq("rerun_dones", done_cnt - base_done, 1);

            n = 0;
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
         end
      join_any
   end

endmodule
